// File: rtl/alu_result_streamer.sv
// alu_result_streamer: snapshots a flat result matrix on start and streams its elements out over valid/ready
module alu_result_streamer #(
  parameter int ELEM_W  = 8,
  parameter int N_ELEMS = 25,
  parameter int IDX_W   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ELEM_W*N_ELEMS-1:0] C_flat,
  input  logic                      overflow_flag,
  output logic [ELEM_W-1:0]         out_data,
  output logic [IDX_W-1:0]          out_index,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done,
  output logic                      ovf_latched
);
  localparam logic [1:0] IDLE = 2'd0, STREAM = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [ELEM_W*N_ELEMS-1:0] shadow;
  logic [IDX_W-1:0] idx;
  logic at_end;
  assign at_end    = idx == IDX_W'(N_ELEMS - 1);
  assign out_valid = state == STREAM;
  assign out_data  = out_valid ? shadow[idx*ELEM_W +: ELEM_W] : '0;
  assign out_index = out_valid ? idx : '0;
  assign out_last  = out_valid && at_end;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      shadow      <= '0;
      idx         <= '0;
      ovf_latched <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        shadow      <= C_flat;
        ovf_latched <= overflow_flag;
        idx         <= '0;
        state       <= STREAM;
      end
    end else if (state == STREAM) begin
      if (out_ready) begin
        if (at_end) state <= DONE;
        else idx <= idx + IDX_W'(1);
      end
    end else begin
      state <= IDLE;
    end
endmodule
